// File: rtl/pll_rst_seq.sv
// pll_rst_seq: reset/lock sequencer for the system PLL.
// Pulses the PLL reset, waits for a synchronized lock that stays stable,
// retries a bounded number of times, then reports failure.
// Runs on the PLL reference clock so it keeps working without PLL output.
// Optional build macro: PLL_RST_SEQ_LOSS_CNT_EN adds lost_cnt, a saturating
// count of lock losses seen while READY.
module pll_rst_seq #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sw_relock,
  output logic       pll_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lost_cnt
`endif
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int unsigned CNT_MAX = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_MX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             sync1_q, sync2_q;
  logic             lock_s;
  logic             pll_reset_q, ready_q, fail_q;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0]       lost_q, lost_d;
`endif

  assign lock_s = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter and retry bookkeeping; sw_relock overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    lost_d  = lost_q;
`endif
    if (sw_relock) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = ST_RESET_PLL;
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        ST_READY: begin
          // Counter is idle here; hold it at zero instead of free-running.
          cnt_d = '0;
          if (!lock_s) begin
            state_d = ST_RESET_PLL;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
`endif
          end
        end
        ST_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == ST_RESET_PLL);
      ready_q     <= (state_d == ST_READY);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  // Lock-loss counter; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lost_q <= '0;
    else        lost_q <= lost_d;
  end

  assign lost_cnt = lost_q;
`endif

  assign pll_reset = pll_reset_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Sequencer that sits directly upstream of the system PLL (GW2A-18 rPLL wrapper, 27 MHz reference).
- Drives the PLL's active-high reset, watches its asynchronous lock output, and requires lock to stay stable before declaring the clock tree ready.
- Retries a bounded number of times, then reports failure.
- Runs on the PLL reference clock, so it keeps working while the PLL output is absent.

Parameters:
- RST_CYCLES, 16: width of each PLL reset pulse, in clk cycles (≥1).
- LOCK_STABLE, 1024: cycles the synchronized lock must stay high before ready (≥1).
- LOCK_TIMEOUT, 65535: cycles to wait for lock after reset release before a retry (≥1).
- MAX_RETRY, 7: retries allowed after the initial attempt before FAIL (0..15).

Ports:
- clk  input  1  reference clock (same net as the PLL input clock)
- rst_n  input  1  asynchronous active-low reset
- pll_lock  input  1  PLL lock, asynchronous to clk
- sw_relock  input  1  single-cycle request to restart the sequence
- pll_reset  output  1  active-high reset to the PLL
- ready  output  1  PLL locked and stable
- fail  output  1  retries exhausted
- retry_cnt  output  4  retries consumed in the current attempt series
- state  output  3  debug: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 READY, 4 FAIL

Behaviour:
- Reset values while rst_n=0: state=RESET_PLL, pll_reset=1, ready=0, fail=0, retry_cnt=0, internal counter=0, both synchronizer flops=0.
- Reset is asynchronous assert, synchronous release (clock-edge sampled).
- pll_lock passes through a 2-flop synchronizer to give lock_s. There is no other use of raw pll_lock.
- All outputs are registered. ready=(state==READY), fail=(state==FAIL), pll_reset=(state==RESET_PLL).
- A single counter is cleared on every state entry. Its width is clog2 of the largest of the three cycle parameters.
- RESET_PLL: stays exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1 → STABLE.
  - Otherwise, at count==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY → FAIL; else retry_cnt+1 and → RESET_PLL.
- STABLE:
  - lock_s=0 → WAIT_LOCK. The timeout restarts and retry_cnt is unchanged.
  - Otherwise, at count==LOCK_STABLE-1 → READY.
- READY:
  - retry_cnt is cleared on entry.
  - lock_s=0 → RESET_PLL. There is no retry increment, so loss of lock is a fresh series.
- FAIL: pll_reset=0. Held until sw_relock or rst_n.
- sw_relock=1 in any state, including RESET_PLL, takes priority over every other transition:
  - → RESET_PLL;
  - retry_cnt=0;
  - counter restarts, so the pulse is a full RST_CYCLES.
- Latency:
  - pll_lock rise to ready rise = LOCK_STABLE+3 cycles (2 sync, 1 WAIT→STABLE, LOCK_STABLE count).
  - lock_s fall in READY to ready fall = 1 cycle; pll_reset rises on the same edge.
- Lock high during RESET_PLL is ignored.
- Lock already high on entry to WAIT_LOCK → STABLE on the next edge.

Optional Feature:
- Macro PLL_RST_SEQ_LOSS_CNT_EN.
- Defined:
  - Adds output lost_cnt (8 bits, reset 0).
  - Increments by one on every READY→RESET_PLL transition caused by lock_s=0.
  - Saturates at 255.
  - Cleared only by rst_n; sw_relock does not clear it.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2):
- Release rst_n, raise pll_lock 10 cycles after pll_reset falls → pll_reset high exactly 4 cycles after release; ready rises 11 cycles after pll_lock; retry_cnt=0; state=3.
- Lock high 5 cycles then low for 1 cycle while in STABLE, then high again → state returns to 1 and ready stays 0; ready rises 11 cycles after the second rise; retry_cnt=0.
- pll_lock held 0 → three 4-cycle pll_reset pulses, each separated by 32 cycles; retry_cnt steps 0→1→2; then fail=1, pll_reset=0, state=4, permanently.
- In READY, drop pll_lock → ready falls and pll_reset rises 3 cycles after the drop; 4-cycle pulse; relock with lock restored gives ready again. With the macro defined, lost_cnt=1.
- In FAIL, pulse sw_relock 1 cycle → fail=0 and retry_cnt=0 next edge; a new 4-cycle pll_reset pulse starts.
- Assert rst_n=0 mid WAIT_LOCK (retry_cnt=1) → pll_reset=1, retry_cnt=0, state=0 without waiting for a clock edge; normal sequence after release.
